// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register file write port between the ALU writeback
//   path and the long-latency MDU (mul/div/load) path. A round-robin
//   valid/ready arbiter feeds a one-deep registered write stage. A pending
//   scoreboard tracks MDU destinations so decode can stall RAW/WAW hazards.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   alu_valid/alu_ready/reg/data     ALU writeback request channel
//   mdu_valid/mdu_ready/reg/data     MDU writeback request channel
//   iss_valid/iss_reg/iss_ready      MDU issue, marks destination pending
//   chk_reg1/chk_reg2/chk_busy       decode hazard query (combinational)
//   RegWrite/Write_reg/Write_data    registered register file write port
//   sb_err                           sticky: MDU wrote a non-pending reg
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_reg,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_reg,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] chk_reg1,
    input  logic [ADDR_W-1:0] chk_reg2,
    output logic              chk_busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    output logic              sb_err
);

    typedef enum logic {SRC_ALU = 1'b0, SRC_MDU = 1'b1} src_e;

    src_e                last_q;
    logic                regwrite_q;
    logic [ADDR_W-1:0]   wreg_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                from_mdu_q;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                sb_err_q, sb_err_d;
    logic                alu_xfer, mdu_xfer, iss_xfer;

    // Grant goes to the lone requester, or on a tie to whoever lost last.
    assign alu_ready = alu_valid && (!mdu_valid || (last_q == SRC_MDU));
    assign mdu_ready = mdu_valid && (!alu_valid || (last_q == SRC_ALU));
    assign alu_xfer  = alu_valid && alu_ready;
    assign mdu_xfer  = mdu_valid && mdu_ready;

    // No bypass of a clear happening this edge: a re-issue waits one cycle.
    assign iss_ready = !pend_q[iss_reg];
    assign iss_xfer  = iss_valid && iss_ready;
    assign chk_busy  = pend_q[chk_reg1] | pend_q[chk_reg2];

    assign RegWrite   = regwrite_q;
    assign Write_reg  = wreg_q;
    assign Write_data = wdata_q;
    assign sb_err     = sb_err_q;

    always_comb begin
        pend_d = pend_q;
        // Clear lands on the same edge the register file commits the value.
        if (regwrite_q && from_mdu_q)
            pend_d[wreg_q] = 1'b0;
        if (iss_xfer)
            pend_d[iss_reg] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (mdu_xfer && (mdu_reg != '0) && !pend_q[mdu_reg])
            sb_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= SRC_MDU;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            from_mdu_q <= 1'b0;
            pend_q     <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
            if (alu_xfer) begin
                // $0 handshakes normally but never raises the write enable.
                regwrite_q <= (alu_reg != '0);
                wreg_q     <= alu_reg;
                wdata_q    <= alu_data;
                from_mdu_q <= 1'b0;
                last_q     <= SRC_ALU;
            end else if (mdu_xfer) begin
                regwrite_q <= (mdu_reg != '0);
                wreg_q     <= mdu_reg;
                wdata_q    <= mdu_data;
                from_mdu_q <= 1'b1;
                last_q     <= SRC_MDU;
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, mdu_valid, mdu_ready;
  logic [AW-1:0] alu_reg, mdu_reg, iss_reg, chk_reg1, chk_reg2, Write_reg;
  logic [DW-1:0] alu_data, mdu_data, Write_data;
  logic          iss_valid, iss_ready, chk_busy, RegWrite, sb_err;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_busy(chk_busy),
    .RegWrite(RegWrite), .Write_reg(Write_reg), .Write_data(Write_data), .sb_err(sb_err)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
    exp_q.push_back({r, d});
  endtask

  // Monitor: every asserted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RegWrite === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got reg=%0d data=%h want none", Write_reg, Write_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({Write_reg, Write_data} !== e) begin
          bad++;
          $display("FAIL wr_match: got reg=%0d data=%h want reg=%0d data=%h",
                   Write_reg, Write_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h11;
    mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'h22;
    iss_valid = 1'b0; iss_reg = '0; chk_reg1 = '0; chk_reg2 = '0;
    #22;
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_wreg", Write_reg, 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_sberr", sb_err, 1'b0);
    chk("rst_busy", chk_busy, 1'b0);
    rst_n = 1'b1; #1;

    // Round robin A,M,A,M with the ALU winning the first tie.
    chk("rr0_alu_rdy", alu_ready, 1'b1);
    chk("rr0_mdu_rdy", mdu_ready, 1'b0);
    expect_wr(5'd3, 32'h11);
    tick();
    chk("rr1_alu_rdy", alu_ready, 1'b0);
    chk("rr1_mdu_rdy", mdu_ready, 1'b1);
    chk("rr1_regwrite", RegWrite, 1'b1);
    expect_wr(5'd5, 32'h22);
    tick();
    chk("rr2_alu_rdy", alu_ready, 1'b1);
    chk("rr2_regwrite", RegWrite, 1'b1);
    expect_wr(5'd3, 32'h11);
    tick();
    chk("rr3_mdu_rdy", mdu_ready, 1'b1);
    chk("rr3_regwrite", RegWrite, 1'b1);
    expect_wr(5'd5, 32'h22);
    tick();
    alu_valid = 1'b0; mdu_valid = 1'b0;
    chk("rr4_regwrite", RegWrite, 1'b1);
    tick();
    chk("rr5_idle", RegWrite, 1'b0);
    chk("rr5_hold_reg", Write_reg, 5);
    chk("rr5_hold_data", Write_data, 32'h22);

    // Fresh reset clears the sticky error raised by the unissued MDU writes.
    rst_n = 1'b0; #3;
    chk("rst2_sberr", sb_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ALU write to $0: handshake ok, no write enable.
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEADBEEF; #1;
    chk("r0_alu_rdy", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk("r0_regwrite", RegWrite, 1'b0);

    // Scoreboard lifecycle for reg 7.
    iss_valid = 1'b1; iss_reg = 5'd7; #1;
    chk("s7_iss_rdy0", iss_ready, 1'b1);
    tick();
    iss_valid = 1'b0; chk_reg1 = 5'd7; chk_reg2 = 5'd0; #1;
    chk("s7_busy", chk_busy, 1'b1);
    iss_valid = 1'b1; #1;
    chk("s7_waw", iss_ready, 1'b0);
    iss_valid = 1'b0;
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'hCAFE; #1;
    chk("s7_mdu_rdy", mdu_ready, 1'b1);
    expect_wr(5'd7, 32'hCAFE);
    tick();
    mdu_valid = 1'b0;
    chk("s7_regwrite", RegWrite, 1'b1);
    chk("s7_busy_pre", chk_busy, 1'b1);
    tick();
    chk("s7_busy_post", chk_busy, 1'b0);
    chk("s7_iss_rdy1", iss_ready, 1'b1);
    chk("s7_sberr", sb_err, 1'b0);

    // MDU write to an unissued register raises sticky sb_err.
    mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h99;
    expect_wr(5'd9, 32'h99);
    tick();
    mdu_valid = 1'b0;
    chk("s9_sberr", sb_err, 1'b1);
    tick(); tick(); tick();
    chk("s9_sberr_sticky", sb_err, 1'b1);

    // Async reset mid-write with reg 4 pending.
    iss_valid = 1'b1; iss_reg = 5'd4;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd6; alu_data = 32'h66;
    expect_wr(5'd6, 32'h66);
    tick();
    alu_valid = 1'b0;
    chk_reg1 = 5'd4; #1;
    chk("r4_busy_pre", chk_busy, 1'b1);
    chk("r4_regwrite_pre", RegWrite, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("r4_async_regwrite", RegWrite, 1'b0);
    chk("r4_sberr", sb_err, 1'b0);
    #10 rst_n = 1'b1;
    tick();
    chk("r4_busy_post", chk_busy, 1'b0);
    chk("r4_regwrite_post", RegWrite, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources:
  - the ALU path (single-cycle results);
  - the multiply/divide/load path (MDU, long latency).
- Round-robin arbitration on a valid/ready handshake per source, with a registered write stage that drives RegWrite/Write_reg/Write_data.
- Keeps a pending-write scoreboard for MDU destinations so decode can stall RAW/WAW hazards.
- Sits between the execute/writeback stages and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request granted this cycle
alu_reg  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mdu_valid  input  1  MDU writeback request
mdu_ready  output  1  MDU request granted this cycle
mdu_reg  input  ADDR_W  MDU destination register
mdu_data  input  DATA_W  MDU result
iss_valid  input  1  MDU op issuing, marks iss_reg pending
iss_reg  input  ADDR_W  destination of issuing MDU op
iss_ready  output  1  issue accepted (no WAW conflict)
chk_reg1  input  ADDR_W  decode source operand 1
chk_reg2  input  ADDR_W  decode source operand 2
chk_busy  output  1  either source register pending
RegWrite  output  1  register file write enable (registered)
Write_reg  output  ADDR_W  register file write address (registered)
Write_data  output  DATA_W  register file write data (registered)
sb_err  output  1  sticky: MDU wrote a non-pending register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - RegWrite=0, Write_reg=0, Write_data=0, sb_err=0.
  - All pending bits 0; last_grant=MDU, so the ALU wins the first tie.
- Reset mid-operation drops any output-stage write and clears the scoreboard.
- Handshake:
  - A transfer occurs when valid&&ready at a rising edge.
  - The source must hold valid, reg and data stable until ready.
  - ready is combinational from valid and last_grant. It never depends on the register file.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid: the source not granted last is granted (round-robin).
  - last_grant updates only on a transfer.
  - At most one grant per cycle; no idle cycle is inserted between back-to-back grants.
- Write stage:
  - Latency is 1 cycle: a transfer at edge N drives RegWrite=1, Write_reg, Write_data during cycle N..N+1. The register file commits at edge N+1.
  - No transfer at edge N gives RegWrite=0 next cycle; Write_reg and Write_data hold their values.
  - Transfer to register 0: the handshake completes but RegWrite stays 0, so $0 is never written.
- Scoreboard (one bit per register; bit 0 is hardwired to 0):
  - iss_ready = !pending[iss_reg]. It is combinational and does not bypass a same-cycle clear.
  - iss_valid&&iss_ready at an edge sets pending[iss_reg]. iss_reg=0 is accepted but nothing is set.
  - At the edge where RegWrite=1 and the output stage originated from the MDU, pending[Write_reg] is cleared. This coincides with the register file commit.
  - An ALU write never clears a pending bit.
  - chk_busy = pending[chk_reg1] | pending[chk_reg2]. It is combinational and is 0 for register 0.
  - Set and clear of the same register at the same edge cannot occur, because iss_ready is 0 while the bit is pending. Set and clear of different registers at the same edge both take effect.
- sb_err: set at the edge an MDU transfer targets a nonzero register whose pending bit is 0. It is cleared only by reset.

Test Plan:
- Reset with both valid held high: after release, alu_ready=1 and mdu_ready=0 in the first cycle. Next cycle RegWrite=1 with the ALU's reg/data.
- Both valid for 4 cycles (alu_reg=3/0x11, mdu_reg=5/0x22): grants alternate A,M,A,M. Write_reg sequence is 3,5,3,5 with one-cycle latency and no gaps.
- ALU transfer to reg 0, data 0xDEADBEEF: alu_ready=1 and RegWrite stays 0 the next cycle.
- Issue reg 7, then chk_reg1=7: chk_busy=1. Second issue to 7 gives iss_ready=0. MDU writes 7 (0xCAFE): RegWrite=1 one cycle after the transfer; chk_busy=0 and iss_ready=1 the cycle after the commit edge; sb_err stays 0.
- MDU writes reg 9 with nothing issued: write proceeds and sb_err=1 persists until rst_n=0.
- rst_n asserted with RegWrite=1 and reg 4 pending: RegWrite=0 immediately (asynchronously) and chk_busy for reg 4 is 0 after release.
